// File: rtl/token_intake_if.sv
// Handshake bundle between the token sensor front end and its batch consumer.
// The master drives sensor/enable/ack; the slave (token_intake) drives the status outputs.
interface token_intake_if;
    logic       sensor_in;
    logic       enable;
    logic       ack;
    logic [3:0] count_out;
    logic       valid;
    logic       busy;
    logic       jam;
    logic       missed;
    logic [2:0] state_out;

    modport master (
        output sensor_in,
        output enable,
        output ack,
        input  count_out,
        input  valid,
        input  busy,
        input  jam,
        input  missed,
        input  state_out
    );

    modport slave (
        input  sensor_in,
        input  enable,
        input  ack,
        output count_out,
        output valid,
        output busy,
        output jam,
        output missed,
        output state_out
    );
endinterface

// File: rtl/token_intake.sv
// Optical token counter: synchronizes and debounces a beam sensor, groups tokens
// into batches of up to 15, reports each batch until acknowledged, and flags jams.
module token_intake #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter logic [23:0] IDLE_TIMEOUT    = 24'd500000,
    parameter logic [23:0] JAM_CYCLES      = 24'd2000000
) (
    input  logic          clock,
    input  logic          reset,
    token_intake_if.slave bus
);
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_COUNT  = 3'b001,
        ST_JAM    = 3'b010,
        ST_REPORT = 3'b011
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sensor_sync;

    logic        filt_q, filt_d;
    logic        filt_prev_q, filt_prev_d;
    logic [15:0] deb_cnt_q, deb_cnt_d;

    logic [23:0] jam_cnt_q, jam_cnt_d;
    logic [23:0] idle_cnt_q, idle_cnt_d;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        missed_q, missed_d;

    logic        token_evt;
    logic        jam_hit;
    logic        idle_hit;

    // Synchronizer chain: stage 0 samples the raw pin, later stages shift.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_d[gi] = bus.sensor_in;
        end else begin : g_next
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    assign sensor_sync = sync_q[SYNC_STAGES-1];

    // Debounce: the run counter only advances while the synchronized level
    // disagrees with the filtered one, and clears on agreement or on a flip.
    always_comb begin
        deb_cnt_d = '0;
        filt_d    = filt_q;
        if (sensor_sync != filt_q) begin
            if ((deb_cnt_q + 16'd1) >= DEBOUNCE_CYCLES) begin
                filt_d = sensor_sync;
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end
    end

    assign filt_prev_d = filt_q;
    assign token_evt   = filt_prev_q & ~filt_q;

    always_comb begin
        jam_cnt_d = '0;
        if (filt_q) begin
            jam_cnt_d = (jam_cnt_q >= JAM_CYCLES) ? jam_cnt_q : jam_cnt_q + 24'd1;
        end
    end

    assign jam_hit  = (jam_cnt_q >= JAM_CYCLES);
    assign idle_hit = (idle_cnt_q >= IDLE_TIMEOUT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            deb_cnt_q   <= '0;
            jam_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            count_q     <= '0;
            missed_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            jam_cnt_q   <= jam_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            state_q     <= state_d;
            count_q     <= count_d;
            missed_q    <= missed_d;
        end
    end

    // Batch FSM. A jam pre-empts everything outside JAM, so a token that
    // coincides with jam detection is dropped rather than counted or missed.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        missed_d   = 1'b0;
        idle_cnt_d = '0;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (jam_hit) begin
                    state_d = ST_JAM;
                end else if (token_evt) begin
                    if (bus.enable) begin
                        state_d = ST_COUNT;
                        count_d = 4'd1;
                    end else begin
                        missed_d = 1'b1;
                    end
                end
            end

            ST_COUNT: begin
                if (jam_hit) begin
                    state_d = ST_JAM;
                end else if (token_evt) begin
                    if (count_q != 4'd15) begin
                        count_d = count_q + 4'd1;
                    end
                    if (count_q >= 4'd14) begin
                        state_d = ST_REPORT;
                    end
                end else if (idle_hit) begin
                    state_d = ST_REPORT;
                end else if (filt_q) begin
                    idle_cnt_d = idle_cnt_q;
                end else begin
                    idle_cnt_d = idle_cnt_q + 24'd1;
                end
            end

            ST_REPORT: begin
                if (jam_hit) begin
                    state_d = ST_JAM;
                end else begin
                    missed_d = token_evt;
                    if (bus.ack) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
            end

            ST_JAM: begin
                // The falling edge that ends the jam is swallowed here.
                if (!filt_q) begin
                    state_d = (count_q != 4'd0) ? ST_REPORT : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign bus.count_out = count_q;
    assign bus.valid     = (state_q == ST_REPORT);
    assign bus.busy      = (state_q == ST_COUNT);
    assign bus.jam       = (state_q == ST_JAM);
    assign bus.missed    = missed_q;
    assign bus.state_out = state_q;

endmodule

// File: tb/tb_token_intake.sv
// Randomized and directed checks of token_intake against a history-based
// behavioural model of the filter, timers and batch rules.
module tb_token_intake;
    localparam int DEB    = 4;
    localparam int IDLE_T = 20;
    localparam int JAMC   = 50;
    localparam int MAXC   = 8192;

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_COUNT  = 3'b001;
    localparam logic [2:0] S_JAM    = 3'b010;
    localparam logic [2:0] S_REPORT = 3'b011;

    logic clock = 1'b0;
    logic reset = 1'b0;

    token_intake_if bus ();

    token_intake #(
        .DEBOUNCE_CYCLES(16'd4),
        .IDLE_TIMEOUT   (24'd20),
        .JAM_CYCLES     (24'd50)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int missed_seen = 0;

    // Model: raw_h[i] is the raw sensor value sampled at edge i, f_h[i] the
    // filtered level after edge i; index 0 is the state right after reset.
    logic raw_h [MAXC];
    logic f_h   [MAXC];
    int   mk;
    logic [2:0] m_st;
    int   m_cnt;
    int   m_idle;
    logic m_missed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic raw_at(input int i);
        if (i < 0) return 1'b0;
        return raw_h[i];
    endfunction

    function automatic logic f_at(input int i);
        if (i < 0) return 1'b0;
        return f_h[i];
    endfunction

    function automatic logic [10:0] dut_vec();
        return {bus.state_out, bus.count_out, bus.valid, bus.busy, bus.jam, bus.missed};
    endfunction

    function automatic logic [10:0] model_vec();
        return {m_st, m_cnt[3:0], (m_st == S_REPORT), (m_st == S_COUNT), (m_st == S_JAM), m_missed};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAXC; i++) begin
            raw_h[i] = 1'b0;
            f_h[i]   = 1'b0;
        end
        mk       = 0;
        m_st     = S_IDLE;
        m_cnt    = 0;
        m_idle   = 0;
        m_missed = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic en, input logic a);
        logic fk, fnext, flip, tok, jh, mis_n;
        int run, cnt_n, idle_n;
        logic [2:0] st_n;
        fk = f_at(mk);
        // Filter flips once the last DEB synchronized samples all disagree with it.
        flip = 1'b1;
        for (int i = 1; i <= DEB; i++) begin
            if (raw_at(mk - i) == fk) flip = 1'b0;
        end
        fnext = flip ? ~fk : fk;
        tok = f_at(mk - 1) && !fk;
        run = 0;
        for (int i = mk - 1; i >= 0; i--) begin
            if (!f_h[i] || run >= JAMC) break;
            run++;
        end
        jh = (run >= JAMC);

        st_n = m_st; cnt_n = m_cnt; idle_n = 0; mis_n = 1'b0;
        if (m_st != S_JAM && jh) begin
            st_n = S_JAM;
        end else begin
            case (m_st)
                S_IDLE: if (tok) begin
                    if (en) begin st_n = S_COUNT; cnt_n = 1; end
                    else mis_n = 1'b1;
                end
                S_COUNT: begin
                    if (tok) begin
                        cnt_n = m_cnt + 1;
                        if (cnt_n == 15) st_n = S_REPORT;
                    end else if (m_idle == IDLE_T) begin
                        st_n = S_REPORT;
                    end else begin
                        idle_n = fk ? m_idle : m_idle + 1;
                    end
                end
                S_REPORT: begin
                    mis_n = tok;
                    if (a) begin st_n = S_IDLE; cnt_n = 0; end
                end
                default: if (!fk) st_n = (m_cnt > 0) ? S_REPORT : S_IDLE;
            endcase
        end
        raw_h[mk + 1] = r;
        f_h[mk + 1]   = fnext;
        mk++;
        m_st = st_n; m_cnt = cnt_n; m_idle = idle_n; m_missed = mis_n;
    endtask

    task automatic step(input logic r, input logic en, input logic a);
        bus.sensor_in = r;
        bus.enable    = en;
        bus.ack       = a;
        model_step(r, en, a);
        @(posedge clock);
        @(negedge clock);
        if (bus.missed) missed_seen++;
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic pulse(input int hi, input int lo, input logic en);
        repeat (hi) step(1'b1, en, 1'b0);
        repeat (lo) step(1'b0, en, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_ack();
        step(1'b0, 1'b1, 1'b1);
        check("ack_state", bus.state_out, S_IDLE);
        check("ack_count", bus.count_out, 0);
        check("ack_valid", bus.valid, 0);
        idle_cycles(3);
    endtask

    initial begin
        int ms, len, cyc_rand;
        logic lvl;
        bus.sensor_in = 1'b0;
        bus.enable    = 1'b0;
        bus.ack       = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_state", dut_vec(), 0);
        reset = 1'b1;

        // Three clean pulses form one batch reported after the idle timeout.
        pulse(10, 8, 1'b1);
        check("s1_busy", bus.busy, 1);
        pulse(10, 8, 1'b1);
        pulse(10, 8, 1'b1);
        idle_cycles(40);
        check("s1_valid", bus.valid, 1);
        check("s1_count", bus.count_out, 3);
        do_ack();
        $display("scenario basic_batch done at %0t", $time);

        // Short glitches never register; a 5-cycle pulse counts once.
        for (int g = 0; g < 8; g++) pulse($urandom_range(1, 3), $urandom_range(3, 8), 1'b1);
        check("s2_glitch_state", bus.state_out, S_IDLE);
        check("s2_glitch_count", bus.count_out, 0);
        pulse(5, 8, 1'b1);
        check("s2_one_count", bus.count_out, 1);
        check("s2_busy", bus.busy, 1);
        idle_cycles(30);
        check("s2_report", bus.state_out, S_REPORT);
        do_ack();
        $display("scenario glitch done at %0t", $time);

        // Fifteen tokens fill a batch; the sixteenth is reported as missed.
        for (int t = 0; t < 15; t++) pulse($urandom_range(5, 8), $urandom_range(8, 10), 1'b1);
        check("s3_report", bus.state_out, S_REPORT);
        check("s3_count15", bus.count_out, 15);
        ms = missed_seen;
        pulse(6, 10, 1'b1);
        check("s3_missed_once", missed_seen - ms, 1);
        check("s3_count_hold", bus.count_out, 15);
        do_ack();
        $display("scenario full_batch done at %0t", $time);

        // Jam during a batch of two; release resumes the report with count 2.
        pulse(6, 8, 1'b1);
        pulse(6, 8, 1'b1);
        repeat (60) step(1'b1, 1'b1, 1'b0);
        check("s4_jam", bus.jam, 1);
        check("s4_jam_valid", bus.valid, 0);
        check("s4_jam_count", bus.count_out, 2);
        idle_cycles(12);
        check("s4_after_jam", bus.state_out, S_REPORT);
        check("s4_after_count", bus.count_out, 2);
        do_ack();
        $display("scenario jam done at %0t", $time);

        // Disabled intake flags a miss, then enabled intake starts a batch.
        ms = missed_seen;
        pulse(6, 8, 1'b0);
        check("s5_missed", missed_seen - ms, 1);
        check("s5_idle", bus.state_out, S_IDLE);
        pulse(6, 8, 1'b1);
        check("s5_count_state", bus.state_out, S_COUNT);
        check("s5_count1", bus.count_out, 1);
        idle_cycles(30);
        do_ack();
        $display("scenario enable done at %0t", $time);

        // Asynchronous reset while reporting a batch of four.
        for (int t = 0; t < 4; t++) pulse(6, 8, 1'b1);
        idle_cycles(30);
        check("s6_report_count", bus.count_out, 4);
        check("s6_report_state", bus.state_out, S_REPORT);
        reset = 1'b0;
        #1;
        check("s6_async_reset", dut_vec(), 0);
        repeat (2) @(negedge clock);
        check("s6_held_reset", dut_vec(), 0);
        model_reset();
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b1);
        check("s6_ack_ignored", dut_vec(), 0);
        $display("scenario reset done at %0t", $time);

        // Random sensor activity with occasional jams, random enable and ack.
        lvl = 1'b0;
        cyc_rand = 0;
        while (cyc_rand < 1500) begin
            lvl = ~lvl;
            if (lvl && $urandom_range(0, 9) == 0) len = $urandom_range(52, 64);
            else len = $urandom_range(1, 12);
            repeat (len) begin
                step(lvl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
                cyc_rand++;
            end
        end
        $display("scenario random done at %0t", $time);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
